// File: rtl/regfile_clr_bypass.sv
// Register file with a power-up clear sequence and an optional write-to-read bypass.
// After reset, a walking counter zeroes entries 1..DEPTH-1 (one per clock). The file then
// enters READY and accepts writes. Entry 0 is hardwired to read zero.
// Optional feature: define REGFILE_BYPASS_EN to forward win to A/B in the write cycle.
module regfile_clr_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rW,
  input  logic [DATA_W-1:0] win,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state and array write port: clear walk in StClear, user writes in StReady.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we    = ~rst;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        // Counter stops at the last entry instead of wrapping.
        if (cnt_q == LastAddr) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StReady: begin
        // Entry 0 is never stored; its read path is forced to zero.
        mem_we    = ~rst & we & (rW != '0);
        mem_waddr = rW;
        mem_wdata = win;
      end
      default: state_d = StClear;
    endcase
  end

  // State register with synchronous reset; reset restarts the clear walk at entry 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: single write port, no reset (the clear walk initialises it).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready = (state_q == StReady);

  // Read port A: zero while clearing or for entry 0.
  always_comb begin
    A = '0;
    if (ready && (rA != '0)) begin
      A = mem_q[rA];
`ifdef REGFILE_BYPASS_EN
      if (we && (rW == rA)) begin
        A = win;
      end
`endif
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    B = '0;
    if (ready && (rB != '0)) begin
      B = mem_q[rB];
`ifdef REGFILE_BYPASS_EN
      if (we && (rW == rB)) begin
        B = win;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_clr_bypass.sv
// Self-checking bench for regfile_clr_bypass: directed scenarios plus a randomized phase,
// checked every cycle against a behavioural model of the register file.
module tb_regfile_clr_bypass;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  rW, rA, rB;
  logic [31:0] win, A, B;
  logic        ready;

  // Small configuration instance.
  logic        s_rst, s_we;
  logic [2:0]  s_rW, s_rA, s_rB;
  logic [15:0] s_win, s_A, s_B;
  logic        s_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_clr_bypass dut (
    .clk(clk), .rst(rst), .we(we), .rW(rW), .win(win),
    .rA(rA), .rB(rB), .A(A), .B(B), .ready(ready)
  );

  regfile_clr_bypass #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .rst(s_rst), .we(s_we), .rW(s_rW), .win(s_win),
    .rA(s_rA), .rB(s_rB), .A(s_A), .B(s_B), .ready(s_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents are all zero after a reset, the file is unusable until
  // DEPTH-1 clean edges have passed, then writes to nonzero addresses take effect.
  logic [31:0] m_mem [DEPTH];
  bit          m_ready = 1'b0;
  bit          m_valid = 1'b0;
  int          m_edges = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0;
      m_edges = 0;
      m_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == DEPTH - 1) m_ready = 1'b1;
    end else if (we && rW != 0) begin
      m_mem[rW] = win;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (!m_ready || addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && rW == addr) return win;
`endif
    return m_mem[addr];
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", {31'b0, ready}, {31'b0, m_ready});
      check("read_A", A, exp_rd(rA));
      check("read_B", B, exp_rd(rB));
    end
  end

  int n;

  initial begin
    rst = 1'b1; we = 1'b0; rW = '0; win = '0; rA = '0; rB = '0;
    s_rst = 1'b1; s_we = 1'b0; s_rW = '0; s_win = '0; s_rA = '0; s_rB = '0;

    // Reset held for 3 cycles, then count edges until ready; poke a write mid-clear.
    repeat (3) @(posedge clk);
    #1 check("ready_in_reset", {31'b0, ready}, 32'd0);
    check("A_in_reset", A, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      #2;
      if (ready) n = i;
      if (i == 9) begin we = 1'b1; rW = 5'd3; win = 32'hFFFF_FFFF; end
      if (i == 10) we = 1'b0;
    end
    check("ready_edges", n, 32'd31);

    // Every entry reads zero after the clear.
    for (int a = 0; a < DEPTH; a++) begin
      rA = 5'(a); rB = 5'(31 - a);
      #1 check("clear_A", A, 32'd0);
      check("clear_B", B, 32'd0);
      @(posedge clk); #1;
    end

    // Basic write and read-back; write to entry 0 is dropped.
    we = 1'b1; rW = 5'd5; win = 32'hDEAD_BEEF; rA = 5'd5; rB = 5'd0;
    @(posedge clk); #1 we = 1'b0;
    #1 check("wr5_A", A, 32'hDEAD_BEEF);
    check("wr5_B", B, 32'd0);
    we = 1'b1; rW = 5'd0; win = 32'h1234; rA = 5'd0;
    @(posedge clk); #1 we = 1'b0;
    #1 check("wr0_A", A, 32'd0);

    // Write during clear was ignored.
    rA = 5'd3;
    #1 check("clear_write_ignored", A, 32'd0);

    // Same-cycle read of the entry being written.
    @(posedge clk); #1;
    we = 1'b1; rW = 5'd7; rA = 5'd7; rB = 5'd7; win = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_A", A, 32'hA5A5_A5A5);
    check("bypass_B", B, 32'hA5A5_A5A5);
`else
    check("nobypass_A", A, 32'd0);
    check("nobypass_B", B, 32'd0);
`endif
    @(posedge clk); #1 we = 1'b0;
    #1 check("after_wr7_A", A, 32'hA5A5_A5A5);
    check("after_wr7_B", B, 32'hA5A5_A5A5);

    // Reset from READY wipes contents and reruns the full clear.
    we = 1'b1; rW = 5'd9; win = 32'h11; rA = 5'd9;
    @(posedge clk); #1 we = 1'b0;
    #1 check("wr9_A", A, 32'h11);
    rst = 1'b1; we = 1'b1; rW = 5'd9; win = 32'h22;
    @(posedge clk); #1 rst = 1'b0; we = 1'b0;
    #1 check("ready_drop", {31'b0, ready}, 32'd0);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      #2;
      if (ready) n = i;
    end
    check("reready_edges", n, 32'd31);
    check("reg9_cleared", A, 32'd0);

    // Randomized phase with occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      we  = 1'($urandom_range(0, 1));
      rW  = 5'($urandom_range(0, 31));
      win = $urandom;
      rA  = ($urandom_range(0, 2) == 0) ? rW : 5'($urandom_range(0, 31));
      rB  = ($urandom_range(0, 2) == 0) ? rW : 5'($urandom_range(0, 31));
    end
    @(posedge clk); #1 rst = 1'b0; we = 1'b0;

    // Small configuration: 8 entries, 16-bit data.
    @(posedge clk); #1 s_rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk);
      #2;
      if (s_ready) n = i;
    end
    check("small_ready_edges", n, 32'd7);
    s_rA = 3'd6;
    #1 check("small_clear", {16'b0, s_A}, 32'd0);
    s_we = 1'b1; s_rW = 3'd6; s_win = 16'hFFFF; s_rB = 3'd6;
    @(posedge clk); #1 s_we = 1'b0;
    #1 check("small_wr_A", {16'b0, s_A}, 32'h0000_FFFF);
    check("small_wr_B", {16'b0, s_B}, 32'h0000_FFFF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
